// File: rtl/control_estados.sv
// -----------------------------------------------------------------------------
// control_estados -- game-phase sequencer for the hero game.
//
// Owns the phase code `presente` (which is also the FSM state register, so it
// doubles as the state debug view) and decides when the power-up greeting,
// hero selection, play and game-over phases start and end.
//
// Optional feature macro: PAUSE_EN
//   defined   -> KEY_PAUSE toggles JUEGO <-> PAUSA (code 4)
//   undefined -> no PAUSA state, KEY_PAUSE ignored in JUEGO
//
// Ports:
//   clk            in   system clock (27 MHz)
//   rst_n          in   asynchronous active-low reset
//   encendido      in   power switch, asynchronous level (synchronized here)
//   keypad_pressed in   keypad press level, asynchronous (synchronized here)
//   key[4:0]       in   key code, valid while keypad_pressed=1
//   cambio         in   menu flag: a non-zero hero is selected
//   heroe[2:0]     in   hero index currently shown by the menu
//   fin_juego      in   one-cycle game-over pulse from the game core
//   presente[3:0]  out  phase: 0 APAGADO,1 HOLA,2 PERSONAJE,3 JUEGO,4 PAUSA,5 FIN
//   heroe_conf[2:0] out hero latched at confirmation, 0 when none
//   inicio_juego   out  one-cycle pulse on entry to JUEGO from PERSONAJE
//
// No valid/ready handshakes here: keypad events are edge-detected levels and
// fin_juego / inicio_juego are single-cycle pulses.
// -----------------------------------------------------------------------------
module control_estados #(
    parameter int unsigned HOLA_TICKS  = 54_000_000,
    parameter int unsigned INACT_TICKS = 270_000_000,
    parameter int unsigned FIN_TICKS   = 81_000_000,
    parameter logic [4:0]  KEY_CONFIRM = 5'd13,
    parameter logic [4:0]  KEY_BACK    = 5'd14,
    parameter logic [4:0]  KEY_PAUSE   = 5'd15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       encendido,
    input  logic       keypad_pressed,
    input  logic [4:0] key,
    input  logic       cambio,
    input  logic [2:0] heroe,
    input  logic       fin_juego,
    output logic [3:0] presente,
    output logic [2:0] heroe_conf,
    output logic       inicio_juego
);

    typedef enum logic [3:0] {
        APAGADO   = 4'd0,
        HOLA      = 4'd1,
        PERSONAJE = 4'd2,
        JUEGO     = 4'd3,
`ifdef PAUSE_EN
        PAUSA     = 4'd4,
`endif
        FIN       = 4'd5
    } estado_t;

    // Timer reload values: a state entered with TICKS-1 and leaving on
    // timer==0 spends exactly TICKS cycles in that state.
    localparam logic [31:0] HOLA_LOAD  = 32'(HOLA_TICKS - 1);
    localparam logic [31:0] INACT_LOAD = 32'(INACT_TICKS - 1);
    localparam logic [31:0] FIN_LOAD   = 32'(FIN_TICKS - 1);

    estado_t     estado;
    logic [31:0] timer;

    logic enc_s1, enc_s2;
    logic kp_s1, kp_s2, kp_d;
    logic pe;
    logic expira;

    // Two-flop synchronizers plus one delay flop for keypad edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_s1 <= 1'b0;
            enc_s2 <= 1'b0;
            kp_s1  <= 1'b0;
            kp_s2  <= 1'b0;
            kp_d   <= 1'b0;
        end else begin
            enc_s1 <= encendido;
            enc_s2 <= enc_s1;
            kp_s1  <= keypad_pressed;
            kp_s2  <= kp_s1;
            kp_d   <= kp_s2;
        end
    end

    // One pulse per press; `key` has long settled by the time the press level
    // emerges from the synchronizer, so it is sampled directly on this cycle.
    assign pe     = kp_s2 & ~kp_d;
    assign expira = (timer == 32'd0);

    assign presente = estado;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= APAGADO;
            heroe_conf   <= 3'd0;
            inicio_juego <= 1'b0;
            timer        <= 32'd0;
        end else begin
            inicio_juego <= 1'b0;
            if (!enc_s2) begin
                // Power off overrides every other condition, from any state.
                estado     <= APAGADO;
                heroe_conf <= 3'd0;
                timer      <= 32'd0;
            end else begin
                case (estado)
                    APAGADO: begin
                        estado <= HOLA;
                        timer  <= HOLA_LOAD;
                    end

                    HOLA: begin
                        if (pe || expira) begin
                            estado <= PERSONAJE;
                            timer  <= INACT_LOAD;
                        end else begin
                            timer <= timer - 32'd1;
                        end
                    end

                    PERSONAJE: begin
                        // A press wins over an expiry landing on the same cycle.
                        if (pe) begin
                            if (key == KEY_CONFIRM && cambio) begin
                                estado       <= JUEGO;
                                heroe_conf   <= heroe;
                                inicio_juego <= 1'b1;
                                timer        <= 32'd0;
                            end else if (key == KEY_BACK) begin
                                estado <= HOLA;
                                timer  <= HOLA_LOAD;
                            end else begin
                                // Includes confirm without a selected hero.
                                timer <= INACT_LOAD;
                            end
                        end else if (expira) begin
                            estado <= HOLA;
                            timer  <= HOLA_LOAD;
                        end else begin
                            timer <= timer - 32'd1;
                        end
                    end

                    JUEGO: begin
                        if (fin_juego) begin
                            estado <= FIN;
                            timer  <= FIN_LOAD;
                        end
`ifdef PAUSE_EN
                        else if (pe && key == KEY_PAUSE) begin
                            estado <= PAUSA;
                        end
`endif
                    end

`ifdef PAUSE_EN
                    PAUSA: begin
                        if (fin_juego) begin
                            estado <= FIN;
                            timer  <= FIN_LOAD;
                        end else if (pe && key == KEY_PAUSE) begin
                            // Resume: no start pulse, hero kept.
                            estado <= JUEGO;
                        end
                    end
`endif

                    FIN: begin
                        if (expira) begin
                            estado     <= PERSONAJE;
                            heroe_conf <= 3'd0;
                            timer      <= INACT_LOAD;
                        end else begin
                            timer <= timer - 32'd1;
                        end
                    end

                    default: begin
                        estado     <= APAGADO;
                        heroe_conf <= 3'd0;
                        timer      <= 32'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_control_estados.sv
// -----------------------------------------------------------------------------
// tb_control_estados -- self-checking bench for control_estados.
// Runs with HOLA_TICKS=10, INACT_TICKS=50, FIN_TICKS=8. Each step pushes the
// expected {presente, heroe_conf, inicio_juego} for the next clock edge onto
// exp_q, then pops and compares it #1 after that edge.
// -----------------------------------------------------------------------------
module tb_control_estados;

    logic       clk;
    logic       rst_n;
    logic       encendido;
    logic       keypad_pressed;
    logic [4:0] key;
    logic       cambio;
    logic [2:0] heroe;
    logic       fin_juego;
    logic [3:0] presente;
    logic [2:0] heroe_conf;
    logic       inicio_juego;

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    control_estados #(
        .HOLA_TICKS (10),
        .INACT_TICKS(50),
        .FIN_TICKS  (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .encendido     (encendido),
        .keypad_pressed(keypad_pressed),
        .key           (key),
        .cambio        (cambio),
        .heroe         (heroe),
        .fin_juego     (fin_juego),
        .presente      (presente),
        .heroe_conf    (heroe_conf),
        .inicio_juego  (inicio_juego)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got presente=%0d heroe_conf=%0d inicio=%0d, expected presente=%0d heroe_conf=%0d inicio=%0d",
                     tag, obs[7:4], obs[3:1], obs[0], exp[7:4], exp[3:1], exp[0]);
        end
    endtask

    task automatic push_exp(input logic [3:0] p, input logic [2:0] h, input logic i);
        exp_q.push_back({p, h, i});
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got empty queue expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, {presente, heroe_conf, inicio_juego}, e);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step(input string tag, input logic [3:0] p, input logic [2:0] h, input logic i);
        push_exp(p, h, i);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    task automatic steps(input string tag, input int n, input logic [3:0] p, input logic [2:0] h);
        for (int k = 0; k < n; k++) step(tag, p, h, 1'b0);
    endtask

    task automatic press(input logic [4:0] k);
        keypad_pressed = 1'b1;
        key            = k;
    endtask

    task automatic release_key();
        keypad_pressed = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n          = 1'b0;
        encendido      = 1'b0;
        keypad_pressed = 1'b0;
        key            = 5'd0;
        cambio         = 1'b0;
        heroe          = 3'd0;
        fin_juego      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        push_exp(4'd0, 3'd0, 1'b0);
        pop_check("reset");

        // Scenario 1: power-up, 3-cycle latency to HOLA, 10 cycles of HOLA.
        rst_n     = 1'b1;
        encendido = 1'b1;
        steps("s1_apagado", 2, 4'd0, 3'd0);
        steps("s1_hola", 10, 4'd1, 3'd0);
        step("s1_personaje", 4'd2, 3'd0, 1'b0);

        // Scenario 2: confirm hero 3, single start pulse, held key is one event.
        cambio = 1'b1;
        heroe  = 3'd3;
        press(5'd13);
        steps("s2_sync", 2, 4'd2, 3'd0);
        step("s2_inicio", 4'd3, 3'd3, 1'b1);
        steps("s2_hold", 20, 4'd3, 3'd3);
        release_key();
        steps("s2_release", 2, 4'd3, 3'd3);

`ifdef PAUSE_EN
        // Scenario 5: pause toggle, no start pulse on resume.
        press(5'd15);
        steps("s5_sync", 2, 4'd3, 3'd3);
        step("s5_pausa", 4'd4, 3'd3, 1'b0);
        release_key();
        steps("s5_pausa_hold", 2, 4'd4, 3'd3);
        press(5'd15);
        steps("s5_sync2", 2, 4'd4, 3'd3);
        step("s5_resume", 4'd3, 3'd3, 1'b0);
        release_key();
        steps("s5_juego", 2, 4'd3, 3'd3);
`else
        // Without pause support KEY_PAUSE does nothing in JUEGO.
        press(5'd15);
        steps("nopause_ignored", 4, 4'd3, 3'd3);
        release_key();
        steps("nopause_release", 2, 4'd3, 3'd3);
`endif

        // Scenario 4/5: fin_juego together with a KEY_PAUSE event -> FIN.
        press(5'd15);
        steps("s4_sync", 2, 4'd3, 3'd3);
        fin_juego = 1'b1;
        step("s4_fin_entry", 4'd5, 3'd3, 1'b0);
        fin_juego = 1'b0;
        release_key();
        steps("s4_fin", 7, 4'd5, 3'd3);
        step("s4_fin_exit", 4'd2, 3'd0, 1'b0);

        // Scenario 3: confirm without hero is ignored but reloads the timer.
        cambio = 1'b0;
        press(5'd13);
        steps("s3_sync", 2, 4'd2, 3'd0);
        step("s3_ignored", 4'd2, 3'd0, 1'b0);
        release_key();
        steps("s3_inact", 49, 4'd2, 3'd0);
        step("s3_timeout", 4'd1, 3'd0, 1'b0);

        // Any key in HOLA advances; KEY_BACK returns from PERSONAJE.
        press(5'd2);
        steps("hola_sync", 2, 4'd1, 3'd0);
        step("hola_key", 4'd2, 3'd0, 1'b0);
        release_key();
        steps("back_release", 2, 4'd2, 3'd0);
        press(5'd14);
        steps("back_sync", 2, 4'd2, 3'd0);
        step("back_hola", 4'd1, 3'd0, 1'b0);
        release_key();
        steps("back_rel", 2, 4'd1, 3'd0);

        // Back into JUEGO with hero 5.
        cambio = 1'b1;
        heroe  = 3'd5;
        press(5'd13);
        steps("h5_sync", 2, 4'd1, 3'd0);
        step("h5_personaje", 4'd2, 3'd0, 1'b0);
        release_key();
        steps("h5_release", 2, 4'd2, 3'd0);
        press(5'd13);
        steps("h5_sync2", 2, 4'd2, 3'd0);
        step("h5_inicio", 4'd3, 3'd5, 1'b1);
        release_key();
        heroe = 3'd1;
        step("h5_const", 4'd3, 3'd5, 1'b0);

        // Scenario 4b: power drop mid-JUEGO.
        encendido = 1'b0;
        steps("s4_off_sync", 2, 4'd3, 3'd5);
        step("s4_off", 4'd0, 3'd0, 1'b0);
        steps("s4_off_hold", 2, 4'd0, 3'd0);
        encendido = 1'b1;
        steps("s4_on_sync", 2, 4'd0, 3'd0);
        step("s4_on_hola", 4'd1, 3'd0, 1'b0);
        step("s4_mid_hola", 4'd1, 3'd0, 1'b0);

        // Scenario 6: asynchronous reset between clock edges.
        #3;
        rst_n = 1'b0;
        #1;
        push_exp(4'd0, 3'd0, 1'b0);
        pop_check("s6_async_reset");
        @(posedge clk);
        #2;
        push_exp(4'd0, 3'd0, 1'b0);
        pop_check("s6_reset_held");
        rst_n = 1'b1;
        steps("s6_apagado", 2, 4'd0, 3'd0);
        step("s6_hola", 4'd1, 3'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_estados.md
Name: control_estados

Overview:
- Top-level game-phase sequencer for the hero game.
- Owns the `presente` state code consumed by the menu/display block and the game core.
- Decides when power-up greeting, hero selection, play and game-over phases begin and end, from keypad events, the power switch, the menu's hero-selected flag and the game core's end signal.
- Latches the confirmed hero and issues a one-cycle start pulse to the game core.

Parameters:
- HOLA_TICKS, 54_000_000, clk cycles spent in HOLA before auto-advance (2 s at 27 MHz).
- INACT_TICKS, 270_000_000, clk cycles without a key press in PERSONAJE before falling back to HOLA.
- FIN_TICKS, 81_000_000, clk cycles spent in FIN before returning to PERSONAJE.
- KEY_CONFIRM, 5'd13, key code that confirms the hero.
- KEY_BACK, 5'd14, key code that returns from PERSONAJE to HOLA.
- KEY_PAUSE, 5'd15, key code that toggles pause (only with PAUSE_EN).

Ports:
- clk  in  1  system clock, 27 MHz
- rst_n  in  1  asynchronous active-low reset
- encendido  in  1  power switch, asynchronous level
- keypad_pressed  in  1  keypad press level, asynchronous
- key  in  5  key code, valid while keypad_pressed=1
- cambio  in  1  menu flag: a non-zero hero is currently selected
- heroe  in  3  hero index currently shown by the menu
- fin_juego  in  1  one-cycle pulse from the game core: game over
- presente  out  4  phase code: 0 APAGADO, 1 HOLA, 2 PERSONAJE, 3 JUEGO, 4 PAUSA, 5 FIN
- heroe_conf  out  3  hero latched at confirmation; 0 when none
- inicio_juego  out  1  one-cycle pulse on entry to JUEGO from PERSONAJE

Behaviour:
- Reset: clk and reset only; reset is asynchronous and active-low. All flops clear on rst_n=0: presente=0, heroe_conf=0, inicio_juego=0, timer=0, synchronizers=0.
- encendido and keypad_pressed each pass through a 2-flop synchronizer.
- Press event `pe`: a one-cycle pulse on a 0→1 edge of the synchronized keypad_pressed. `key` is sampled on that same cycle; holding a key produces exactly one event.
- Timer: 32-bit down-counter.
  - Loaded on every state entry with that state's TICKS-1.
  - In PERSONAJE, also reloaded with INACT_TICKS-1 on every pe.
  - Expiry = timer==0 while in a timed state. Timer holds at 0 in untimed states.
- Priority 1: synchronized encendido=0 forces presente=APAGADO on the next cycle from any state, and clears heroe_conf and the timer. This overrides all other conditions.
- APAGADO: synchronized encendido=1 → HOLA.
- HOLA:
  - Expiry → PERSONAJE, giving exactly HOLA_TICKS cycles in HOLA.
  - Any pe → PERSONAJE on the next cycle.
- PERSONAJE:
  - pe with KEY_CONFIRM and cambio=1 → JUEGO. heroe_conf<=heroe and inicio_juego=1 for exactly the first JUEGO cycle.
  - pe with KEY_CONFIRM and cambio=0 → ignored; the timer still reloads.
  - pe with KEY_BACK → HOLA.
  - Expiry → HOLA.
  - Any other key → remain; timer reloads.
- JUEGO:
  - fin_juego=1 → FIN.
  - All keys ignored unless PAUSE_EN.
  - heroe_conf is constant while in JUEGO.
- FIN: expiry → PERSONAJE; heroe_conf<=0 on exit; keys ignored.
- Simultaneous events:
  - encendido low beats everything.
  - fin_juego beats a pause key in the same cycle.
  - In PERSONAJE, pe beats expiry: a press arriving on the expiry cycle is processed and expiry is discarded.
- presente only takes codes 0–5; codes 6–15 are never produced. An unreachable state recovers to APAGADO.
- All outputs are registered; presente changes one cycle after the qualifying condition.

Optional Feature:
PAUSE_EN
- Defined:
  - In JUEGO, pe with KEY_PAUSE → PAUSA (code 4).
  - In PAUSA, pe with KEY_PAUSE → JUEGO with no inicio_juego pulse and heroe_conf unchanged.
  - fin_juego in PAUSA → FIN.
  - encendido low still → APAGADO.
- Undefined:
  - State 4 is absent; KEY_PAUSE is ignored in JUEGO.
  - PAUSA logic is not synthesized.

Test Plan:
- Run with HOLA_TICKS=10, INACT_TICKS=50, FIN_TICKS=8.
- Scenario 1: rst_n=0 then 1, encendido=1 → presente goes 0, then 1 three cycles later, stays 1 for 10 cycles, then 2.
- Scenario 2: in PERSONAJE with cambio=1, heroe=3, press key 13 → presente=3, heroe_conf=3, inicio_juego high exactly 1 cycle; key held 20 cycles → no further events.
- Scenario 3: in PERSONAJE with cambio=0, press key 13 → presente stays 2, heroe_conf=0. Then 50 cycles with no press → presente=1.
- Scenario 4: in JUEGO, pulse fin_juego → presente=5 for 8 cycles, then 2 with heroe_conf=0. Drop encendido mid-JUEGO → presente=0 within 3 cycles, heroe_conf=0.
- Scenario 5: PAUSE_EN defined, in JUEGO press key 15 → presente=4; press 15 again → presente=3, no inicio_juego pulse. fin_juego and key 15 in the same cycle → presente=5.
- Scenario 6: assert rst_n=0 asynchronously mid-HOLA, between clock edges → all outputs 0 immediately; release → APAGADO.
